// File: rtl/octree_rom_arbiter_if.sv
// Core-side request/return bundle and ROM-side port of the octree ROM arbiter.
interface octree_rom_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  logic [NUM_CORES-1:0]        core_ren;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_node;
  logic [NUM_CORES-1:0]        core_rsp_valid;
  logic                        rom_ren;
  logic [ADDR_W-1:0]           rom_addr;
  logic [DATA_W-1:0]           rom_dout;
  logic [NUM_CORES-1:0]        grant;
  logic                        idle;

  // Cores and ROM side.
  modport master (
    output core_ren, core_addr, rom_dout,
    input  core_node, core_rsp_valid, rom_ren, rom_addr, grant, idle
  );

  // Arbiter side.
  modport slave (
    input  core_ren, core_addr, rom_dout,
    output core_node, core_rsp_valid, rom_ren, rom_addr, grant, idle
  );
endinterface

// File: rtl/octree_rom_arbiter.sv
// Round-robin sharing of one fixed-latency octree node ROM among NUM_CORES
// ray cores; a core tag rides a shift pipeline to steer each return.
module octree_rom_arbiter #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  octree_rom_arbiter_if.slave  bus
);
  localparam int unsigned ID_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned TAG_W  = ID_W + 1;
  localparam int unsigned PIPE_W = ROM_LATENCY * TAG_W;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]             rr_ptr;
  logic [NUM_CORES-1:0]        inflight;
  logic [PIPE_W-1:0]           tag_pipe;
  logic [NUM_CORES*DATA_W-1:0] node_q;
  logic [NUM_CORES*DATA_W-1:0] node_d;
  logic [NUM_CORES-1:0]        rsp_q;

  logic [NUM_CORES-1:0]   eligible;
  logic [ID_W-1:0]        cand;
  logic [ID_W-1:0]        win_id;
  logic                   win_found;
  logic                   do_grant;
  logic [NUM_CORES-1:0]   grant_c;
  logic [ADDR_W-1:0]      rom_addr_c;
  logic [ROM_LATENCY-1:0] stage_valid;
  logic                   pipe_busy;
  tag_t                   new_tag;
  tag_t                   head;
  logic [NUM_CORES-1:0]   ret_onehot;
  logic [ID_W-1:0]        next_ptr;

  assign eligible = bus.core_ren & ~inflight;

  // First eligible core scanning upward from rr_ptr with wraparound.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_CORES);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign do_grant   = en & win_found;
  assign grant_c    = do_grant ? (NUM_CORES'(1) << win_id) : '0;
  assign rom_addr_c = do_grant ? ADDR_W'(bus.core_addr >> (32'(win_id) * ADDR_W)) : '0;
  assign next_ptr   = ID_W'((32'(win_id) + 1) % NUM_CORES);

  assign new_tag.valid = do_grant;
  assign new_tag.id    = win_id;
  assign head          = tag_t'(tag_pipe[PIPE_W-1 -: TAG_W]);
  assign ret_onehot    = head.valid ? (NUM_CORES'(1) << head.id) : '0;

  // Valid bit of every pipeline stage, for the idle indication.
  for (genvar s = 0; s < ROM_LATENCY; s++) begin : g_stage
    assign stage_valid[s] = tag_pipe[s*TAG_W + TAG_W - 1];
  end
  assign pipe_busy = |stage_valid;

  // Steer the ROM word into the slot of the core named by the head tag.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_node
    assign node_d[i*DATA_W +: DATA_W] = ret_onehot[i] ? bus.rom_dout
                                                      : node_q[i*DATA_W +: DATA_W];
  end

  // Pointer, in-flight flags, tag pipeline and per-core return registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      inflight <= '0;
      tag_pipe <= '0;
      node_q   <= '0;
      rsp_q    <= '0;
    end else begin
      tag_pipe <= (tag_pipe << TAG_W) | PIPE_W'(new_tag);
      node_q   <= node_d;
      rsp_q    <= ret_onehot;
      inflight <= (inflight & ~rsp_q) | grant_c;
      if (do_grant) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  assign bus.grant          = grant_c;
  assign bus.rom_ren        = do_grant;
  assign bus.rom_addr       = rom_addr_c;
  assign bus.core_node      = node_q;
  assign bus.core_rsp_valid = rsp_q;
  assign bus.idle           = ~pipe_busy & ~do_grant;

endmodule

// File: doc/octree_rom_arbiter.md
Name: octree_rom_arbiter

Overview:
- Shares one single-port octree node ROM among NUM_CORES ray processor cores.
- Each core has a request port (ren, addr) and a node return port. The block grants one ROM read per cycle using round-robin.
- Each grant carries a core tag down a fixed-latency pipeline, so returned data is steered to the core that issued the read.
- Sits between the ray processor array and the octant ROM, and replaces fixed per-core ROM ports as the core count scales.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 32, node address width
- DATA_W, 32, node word width
- ROM_LATENCY, 1, cycles from ROM sample edge to valid rom_dout (1..4)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  1 = new grants allowed; 0 = in-flight reads drain, no new grants
- core_ren  in  NUM_CORES  per-core read request, held until that core's rsp_valid
- core_addr  in  NUM_CORES*ADDR_W  packed per-core address (core i at [i*ADDR_W +: ADDR_W]), stable while core_ren is high
- core_node  out  NUM_CORES*DATA_W  packed per-core returned node word, registered, holds last value
- core_rsp_valid  out  NUM_CORES  one-cycle pulse per core when its core_node updates
- rom_ren  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- rom_dout  in  DATA_W  ROM data, ROM_LATENCY cycles after sampled read
- grant  out  NUM_CORES  one-hot core granted this cycle (0 if none)
- idle  out  1  no read in flight and no grant this cycle

Behaviour:
- Reset (async assert, sync deassert) values:
  - core_node = 0, core_rsp_valid = 0, inflight = 0, tag pipeline valid bits = 0.
  - rr_ptr = 0.
  - rom_ren = 0 and grant = 0 because they derive from cleared state and en.
  - idle = 1 once the pipeline is empty.
- Eligibility: eligible[i] = core_ren[i] & ~inflight[i].
- Arbitration (combinational, cycle t):
  - When en=1, the winner is the first eligible core scanning rr_ptr, rr_ptr+1, ... wrapping mod NUM_CORES.
  - grant = onehot(winner), rom_ren = 1, rom_addr = core_addr[winner].
  - With no eligible core or en=0: grant = 0, rom_ren = 0, rom_addr = 0.
- On a grant (end of cycle t):
  - rr_ptr <= (winner + 1) mod NUM_CORES; rr_ptr is unchanged when there is no grant.
  - inflight[winner] <= 1.
  - Tag {valid=1, id=winner} enters a shift pipeline ROM_LATENCY deep.
- Return:
  - In cycle t+ROM_LATENCY the tag is at the pipeline head and rom_dout is valid.
  - At the end of that cycle: core_node[id] <= rom_dout and core_rsp_valid[id] <= 1. All other core_rsp_valid bits are 0.
- Latency:
  - Grant in cycle t gives core_rsp_valid visible in cycle t+ROM_LATENCY+1.
  - inflight[id] clears at the end of the rsp_valid cycle, so a core still holding core_ren in that cycle is not regranted.
  - A core may present its next request from cycle t+ROM_LATENCY+2, giving per-core max throughput of 1 read per ROM_LATENCY+2 cycles.
- Aggregate throughput: one ROM read per cycle when at least ROM_LATENCY+2 cores are requesting.
- Simultaneous events:
  - A return and a new grant in the same cycle are independent.
  - A return to core k and a grant to core j≠k in the same cycle are both legal.
  - Core k cannot be granted while inflight[k] is set.
- Fairness: with every core continuously requesting, a core waits at most NUM_CORES-1 grants.
- Core dropping core_ren before its rsp_valid is illegal. The read still completes and the data is still delivered.
- en deasserted mid-operation: no new grants; in-flight returns still complete. en re-asserted: arbitration resumes from the current rr_ptr.
- Reset mid-operation: every state element clears immediately. ROM data arriving after reset is discarded because tag valid bits are 0. No rsp_valid is produced for reads issued before reset.
- idle = (tag pipeline all invalid) & (grant == 0).

Test Plan:
- NUM_CORES=4, ROM_LATENCY=1, ROM modeled as mem[a]=a^32'hA5A5_0000. Single core 2 requests addr 0x10 at cycle 5 -> grant=4'b0100 and rom_addr=0x10 in cycle 5; core_rsp_valid=4'b0100 and core_node[2]=0xA5A5_0010 in cycle 7; no regrant in cycle 7.
- All 4 cores request continuously after reset -> grants in order 0,1,2,3,0,1... Each core is granted once per 4 cycles. rom_ren is high every cycle from the first grant.
- Cores 1 and 3 request in the same cycle with rr_ptr=2 -> core 3 is granted first, core 1 next cycle, rr_ptr ends at 2.
- en dropped in the cycle after a grant to core 0 -> no further grants, core 0 still gets rsp_valid, idle=1 afterwards. en raised -> arbitration resumes from core 1.
- reset_n pulsed low in the cycle between a grant to core 1 and its return -> no core_rsp_valid, core_node all 0, rr_ptr=0; after release, core 1 (still requesting) is regranted.
- ROM_LATENCY=3, cores 0..3 all requesting -> the return for each grant arrives exactly 4 cycles after the grant, tagged to the correct core. No core is granted twice within 5 cycles.
